core_hazard_unit: RTL and testbench

CORE_HAZARD_UNIT -- requirements
Module: core_hazard_unit

---
 rtl/core_hazard_unit_if.sv | 40 ++++
 rtl/core_hazard_unit.sv | 104 ++++++++++
 tb/tb_core_hazard_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/core_hazard_unit_if.sv
// Hazard-unit handshake bundle: ID-stage fields and pipe controls in, stall/flush/forward out.
interface core_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
);
  localparam int FW = $clog2(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              redirect;
  logic              stall_ext;

  logic              stall_if_id;
  logic              bubble_ex;
  logic              flush_if_id;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [31:0]       stall_count;
  logic [31:0]       flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_memread, redirect, stall_ext,
    input  stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regwrite, id_memread, redirect, stall_ext,
    output stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b,
           stall_count, flush_count
  );
endinterface

// File: rtl/core_hazard_unit.sv
// Pipeline hazard unit: tracks DEPTH post-ID slots, detects load-use, picks forward sources.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module core_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
) (
  input logic               CLOCK,
  input logic               RST_n,
  core_hazard_unit_if.slave hz
);
  localparam int FW = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } slot_t;

  slot_t [DEPTH-1:0] slot;
  slot_t             id_slot;
  logic              load_use;
  logic              stall_int;
  logic              bubble_int;
  logic              flush_int;
  logic              slot0_load;

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = 1'b1;
    id_slot.rd       = hz.id_rd;
    id_slot.regwrite = hz.id_regwrite;
    id_slot.memread  = hz.id_memread;
    id_slot.rs1      = hz.id_rs1;
    id_slot.rs2      = hz.id_rs2;
    id_slot.rs1_used = hz.id_rs1_used;
    id_slot.rs2_used = hz.id_rs2_used;
  end

  assign load_use = hz.id_valid && slot[0].valid && slot[0].memread && (slot[0].rd != '0) &&
                    ((hz.id_rs1_used && (hz.id_rs1 == slot[0].rd)) ||
                     (hz.id_rs2_used && (hz.id_rs2 == slot[0].rd)));

  // Reset gates the outputs so an in-flight stall_ext cannot leak through while RST_n is low.
  assign stall_int  = RST_n && (hz.stall_ext || (load_use && !hz.redirect));
  assign bubble_int = RST_n && !hz.stall_ext && (load_use || hz.redirect);
  assign flush_int  = RST_n && !hz.stall_ext && hz.redirect;
  assign slot0_load = hz.id_valid && !stall_int && !hz.redirect;

  assign hz.stall_if_id = stall_int;
  assign hz.bubble_ex   = bubble_int;
  assign hz.flush_if_id = flush_int;

  // Walk oldest to youngest so the youngest qualifying slot wins; slot 1 loads have no data yet.
  function automatic logic [FW-1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic used,
                                            input slot_t [DEPTH-1:0] s);
    logic [FW-1:0] sel;
    sel = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (s[k].valid && s[k].regwrite && (s[k].rd != '0) && (s[k].rd == rs) &&
          !((k == 1) && s[k].memread))
        sel = FW'(k);
    end
    if (!(s[0].valid && used)) sel = '0;
    return sel;
  endfunction

  assign hz.fwd_a = fwd_sel(slot[0].rs1, slot[0].rs1_used, slot);
  assign hz.fwd_b = fwd_sel(slot[0].rs2, slot[0].rs2_used, slot);

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      slot <= '0;
    end else if (!hz.stall_ext) begin
      slot[0] <= slot0_load ? id_slot : '0;
      for (int k = 1; k < DEPTH; k++) slot[k] <= slot[k-1];
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_int && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_int && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;
`else
  assign hz.stall_count = '0;
  assign hz.flush_count = '0;
`endif
endmodule

// File: tb/tb_core_hazard_unit.sv
// Bench for core_hazard_unit: directed instruction-sequence table, freeze/reset sequence,
// then randomized traffic against a queue-based pipeline model.
module tb_core_hazard_unit;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLOCK = ~CLOCK;

  core_hazard_unit_if #(.REG_AW(REG_AW), .DEPTH(DEPTH)) hz ();
  core_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH)) dut (.CLOCK(CLOCK), .RST_n(RST_n), .hz(hz));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit rw; bit mr; bit redir; bit sx;
    bit e_st; bit e_bub; bit e_fl; int e_fa; int e_fb;
  } vec_t;

  typedef struct { bit v; int rd; bit rw; bit mr; int rs1; int rs2; bit u1; bit u2; } ins_t;

  vec_t tbl[$];
  ins_t pipe[$];

  task automatic drive(input vec_t t);
    hz.id_valid    = t.v;
    hz.id_rs1      = REG_AW'(t.rs1);
    hz.id_rs1_used = t.u1;
    hz.id_rs2      = REG_AW'(t.rs2);
    hz.id_rs2_used = t.u2;
    hz.id_rd       = REG_AW'(t.rd);
    hz.id_regwrite = t.rw;
    hz.id_memread  = t.mr;
    hz.redirect    = t.redir;
    hz.stall_ext   = t.sx;
  endtask

  task automatic chk_outs(input string tag, input int st, input int bub, input int fl,
                          input int fa, input int fb);
    chk({tag, ".stall_if_id"}, hz.stall_if_id, st);
    chk({tag, ".bubble_ex"},   hz.bubble_ex,   bub);
    chk({tag, ".flush_if_id"}, hz.flush_if_id, fl);
    chk({tag, ".fwd_a"},       hz.fwd_a,       fa);
    chk({tag, ".fwd_b"},       hz.fwd_b,       fb);
  endtask

  // Reference: forward source = youngest older instruction writing the EX source register.
  function automatic int model_fwd(input bit second);
    int  src;
    bit  used;
    src  = second ? pipe[0].rs2 : pipe[0].rs1;
    used = second ? pipe[0].u2  : pipe[0].u1;
    if (!pipe[0].v || !used) return 0;
    for (int k = 1; k < DEPTH; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src &&
          !(k == 1 && pipe[k].mr))
        return k;
    return 0;
  endfunction

  vec_t nop;
  initial begin
    nop = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0};
    //        v rs1 u1 rs2 u2 rd rw mr rdr sx   st bub fl fa fb
    tbl.push_back('{1, 1,1, 2,1, 5,1,0,0,0,  0,0,0,0,0});  // add x5,x1,x2
    tbl.push_back('{1, 5,1, 3,1, 6,1,0,0,0,  0,0,0,0,0});  // sub x6,x5,x3
    tbl.push_back('{0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,1,0});  // sub in EX: EX/MEM forward
    tbl.push_back('{1, 1,1, 2,1, 5,1,0,0,0,  0,0,0,0,0});  // add x5
    tbl.push_back('{1,12,1,13,1,11,1,0,0,0,  0,0,0,0,0});  // independent
    tbl.push_back('{1,15,1, 5,1,14,1,0,0,0,  0,0,0,0,0});  // reader of x5 in rs2
    tbl.push_back('{0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,0,2});  // WB forward
    tbl.push_back('{1, 1,1, 0,0, 7,1,1,0,0,  0,0,0,0,0});  // lw x7
    tbl.push_back('{1, 7,1, 7,1, 8,1,0,0,0,  1,1,0,0,0});  // add x8,x7,x7: load-use
    tbl.push_back('{1, 7,1, 7,1, 8,1,0,0,0,  0,0,0,0,0});  // re-issued after stall
    tbl.push_back('{0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,2,2});  // both from WB
    tbl.push_back('{1, 1,1, 0,0, 7,1,1,0,0,  0,0,0,0,0});  // lw x7
    tbl.push_back('{1, 7,1, 0,1, 8,1,0,1,0,  0,1,1,0,0});  // load-use + redirect
    tbl.push_back('{1, 1,1, 0,0, 0,1,0,0,0,  0,0,0,0,0});  // writer of x0
    tbl.push_back('{1, 0,1, 0,1, 3,1,0,0,0,  0,0,0,0,0});  // reader of x0
    tbl.push_back('{0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,0,0});  // x0 never forwarded
    tbl.push_back('{1, 2,1, 0,0, 0,1,1,0,0,  0,0,0,0,0});  // lw x0
    tbl.push_back('{1, 0,1, 0,1, 4,1,0,0,0,  0,0,0,0,0});  // x0 load never stalls
    tbl.push_back('{1, 1,1, 2,1, 5,1,0,0,0,  0,0,0,0,0});  // add x5
    tbl.push_back('{1, 5,1, 3,1, 6,1,0,0,0,  0,0,0,0,0});  // sub x6,x5,x3
    tbl.push_back('{0, 0,0, 0,0, 0,0,0,0,1,  1,0,0,1,0});  // freeze 1
    tbl.push_back('{1, 9,1, 9,1, 9,1,0,1,1,  1,0,0,1,0});  // freeze 2, redirect masked
    tbl.push_back('{0, 0,0, 0,0, 0,0,0,0,1,  1,0,0,1,0});  // freeze 3

    // Reset state, with stall_ext/redirect asserted to prove the outputs are gated.
    drive(nop);
    hz.stall_ext = 1'b1;
    hz.redirect  = 1'b1;
    #12;
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.stall_count", hz.stall_count, 0);
    chk("reset.flush_count", hz.flush_count, 0);
    drive(nop);
    @(negedge CLOCK);
    RST_n = 1'b1;
    #1 chk_outs("post_reset", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge CLOCK);
      drive(tbl[i]);
      #1 chk_outs($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_bub, tbl[i].e_fl,
                  tbl[i].e_fa, tbl[i].e_fb);
    end

    // Still frozen: forwards held, counters reflect 4 stall cycles and 1 flush.
    @(negedge CLOCK);
    drive(nop);
    hz.stall_ext = 1'b1;
    #1 chk_outs("freeze4", 1, 0, 0, 1, 0);
    chk("cnt.stall_count", hz.stall_count, PERF ? 4 : 0);
    chk("cnt.flush_count", hz.flush_count, PERF ? 1 : 0);
    #1 RST_n = 1'b0;
    #1 chk_outs("reset_mid_stall", 0, 0, 0, 0, 0);
    chk("reset_mid_stall.stall_count", hz.stall_count, 0);
    chk("reset_mid_stall.flush_count", hz.flush_count, 0);
    @(negedge CLOCK);
    drive(nop);
    RST_n = 1'b1;
    #1 chk_outs("release", 0, 0, 0, 0, 0);

    // Randomized traffic vs. queue model.
    for (int i = 0; i < DEPTH; i++) pipe.push_back('{0,0,0,0,0,0,0,0});
    begin
      longint s_cnt = 0, f_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        ins_t id;
        bit   lu, e_st, e_bub, e_fl;
        @(negedge CLOCK);
        id.v  = ($urandom_range(0, 3) != 0);
        id.rs1 = $urandom_range(0, 3);  id.rs2 = $urandom_range(0, 3);
        id.rd  = $urandom_range(0, 3);
        id.u1 = $urandom_range(0, 1);   id.u2 = $urandom_range(0, 1);
        id.rw = ($urandom_range(0, 3) != 0);
        id.mr = ($urandom_range(0, 2) == 0);
        hz.id_valid = id.v;  hz.id_rs1 = REG_AW'(id.rs1);  hz.id_rs2 = REG_AW'(id.rs2);
        hz.id_rd = REG_AW'(id.rd);  hz.id_rs1_used = id.u1;  hz.id_rs2_used = id.u2;
        hz.id_regwrite = id.rw;  hz.id_memread = id.mr;
        hz.redirect  = ($urandom_range(0, 7) == 0);
        hz.stall_ext = ($urandom_range(0, 7) == 0);
        #1;
        lu = id.v && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
             ((id.u1 && id.rs1 == pipe[0].rd) || (id.u2 && id.rs2 == pipe[0].rd));
        e_st  = hz.stall_ext ? 1'b1 : (lu && !hz.redirect);
        e_bub = !hz.stall_ext && (lu || hz.redirect);
        e_fl  = !hz.stall_ext && hz.redirect;
        chk_outs($sformatf("rand%0d", cyc), e_st, e_bub, e_fl, model_fwd(0), model_fwd(1));
        chk("rand.stall_count", hz.stall_count, s_cnt);
        chk("rand.flush_count", hz.flush_count, f_cnt);
        @(posedge CLOCK);
        if (PERF && e_st) s_cnt++;
        if (PERF && e_fl) f_cnt++;
        if (!hz.stall_ext) begin
          void'(pipe.pop_back());
          if (id.v && !e_st && !hz.redirect) pipe.push_front(id);
          else pipe.push_front('{0,0,0,0,0,0,0,0});
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
